// File: rtl/padc_ocal.sv
// ---------------------------------------------------------------------------
// padc_ocal - offset calibration and output buffer for the padc_dig stream.
//
// Takes one aligned signed sample per clock. Each calibration averages
// 2**CAL_LOG2N samples, taken while the system shorts the ADC input, to learn
// the ADC offset. In RUN the offset is subtracted from every sample, the
// result is saturated to W bits and written into a small valid/ready FIFO.
//
// Ports
//   clk        clock
//   rstn       asynchronous active-low reset
//   dig_in     raw signed sample, new every cycle
//   cal_start  one-cycle calibration request, honoured only in RUN
//   out_data   FIFO head (offset-corrected sample), held when FIFO is empty
//   out_valid  FIFO not empty
//   out_ready  consumer takes the head when out_valid && out_ready
//   cal_done   one-cycle pulse when offset_o is updated
//   offset_o   current signed offset
//   overflow   sticky flag: a RUN sample was dropped because the FIFO was full;
//              cleared when a calibration starts
// ---------------------------------------------------------------------------
module padc_ocal #(
  parameter int W         = 8,
  parameter int PIPE_LAT  = 7,
  parameter int CAL_LOG2N = 4,
  parameter int DEPTH     = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic signed [W-1:0] dig_in,
  input  logic                cal_start,
  output logic signed [W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                cal_done,
  output logic signed [W-1:0] offset_o,
  output logic                overflow
);

  localparam int AW      = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW      = AW + 1;
  localparam int ACCW    = W + CAL_LOG2N;
  localparam int CAL_N   = 2 ** CAL_LOG2N;
  localparam int CNT_MAX = (PIPE_LAT > CAL_N) ? PIPE_LAT : CAL_N;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  localparam logic [CNTW-1:0] LAT_LAST  = CNTW'(PIPE_LAT - 1);
  localparam logic [CNTW-1:0] CAL_LAST  = CNTW'(CAL_N);
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
  localparam logic [ACCW:0]   RND_HALF  = (ACCW + 1)'(2 ** (CAL_LOG2N - 1));
  localparam logic [CW-1:0]   FIFO_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_WARM       = 2'd0,
    ST_RUN        = 2'd1,
    ST_CAL_SETTLE = 2'd2,
    ST_CAL_ACC    = 2'd3
  } state_t;

  // Clamp a W+1 bit signed value into the W bit signed range. The value is out
  // of range exactly when its two top bits disagree; the top bit gives the side.
  function automatic logic signed [W-1:0] sat_w(input logic signed [W:0] v);
    logic signed [W-1:0] r;
    if (v[W] != v[W-1]) begin
      r = v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      r = v[W-1:0];
    end
    return r;
  endfunction

  state_t                 state_r;
  logic [CNTW-1:0]        cnt_r;
  logic signed [ACCW-1:0] acc_r;
  logic signed [W-1:0]    offset_r;
  logic                   cal_done_r;
  logic                   overflow_r;

  logic signed [W-1:0]    mem_r [DEPTH];
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [CW-1:0]          count_r;
  logic signed [W-1:0]    out_data_r;
  logic                   out_valid_r;

  logic signed [W:0]      corr_s;
  logic signed [W-1:0]    corr_sat_s;
  logic signed [ACCW:0]   rnd_s;
  logic signed [ACCW:0]   avg_s;
  logic                   run_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   drop_s;
  logic [CW-1:0]          count_nxt_s;
  logic [AW-1:0]          rd_nxt_s;
  logic signed [W-1:0]    head_nxt_s;

  // Offset correction and calibration average arithmetic.
  always_comb begin
    corr_s     = {dig_in[W-1], dig_in} - {offset_r[W-1], offset_r};
    corr_sat_s = sat_w(corr_s);
    // Round half up: add half an LSB of the average before the arithmetic shift.
    rnd_s      = {acc_r[ACCW-1], acc_r} + RND_HALF;
    avg_s      = rnd_s >>> CAL_LOG2N;
  end

  // FIFO handshake, push acceptance and next head value.
  always_comb begin
    run_s       = (state_r == ST_RUN);
    pop_s       = out_valid_r && out_ready;
    push_s      = run_s && ((count_r < FIFO_FULL) || pop_s);
    drop_s      = run_s && !push_s;
    count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
    rd_nxt_s    = rd_ptr_r + AW'(pop_s);
    // When the new head is the entry being written this cycle, forward it.
    if (push_s && (wr_ptr_r == rd_nxt_s)) begin
      head_nxt_s = corr_sat_s;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // Control FSM: warm-up, run, calibration settle and accumulate.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= ST_WARM;
      cnt_r      <= '0;
      acc_r      <= '0;
      offset_r   <= '0;
      cal_done_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      cal_done_r <= 1'b0;
      case (state_r)
        ST_WARM: begin
          if (cnt_r == LAT_LAST) begin
            state_r <= ST_RUN;
            cnt_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (cal_start) begin
            state_r    <= ST_CAL_SETTLE;
            cnt_r      <= '0;
            overflow_r <= 1'b0;
          end
        end
        ST_CAL_SETTLE: begin
          if (cnt_r == LAT_LAST) begin
            state_r <= ST_CAL_ACC;
            cnt_r   <= '0;
            acc_r   <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_CAL_ACC: begin
          // cnt_r == CAL_N is the cycle after the last accumulated sample.
          if (cnt_r == CAL_LAST) begin
            offset_r   <= sat_w(avg_s[W:0]);
            cal_done_r <= 1'b1;
            state_r    <= ST_RUN;
            cnt_r      <= '0;
          end else begin
            acc_r <= acc_r + {{CAL_LOG2N{dig_in[W-1]}}, dig_in};
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_WARM;
          cnt_r   <= '0;
        end
      endcase
      // A dropped sample is recorded even on the cycle a calibration starts.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // FIFO storage, pointers and registered head/valid outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= corr_sat_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r    <= rd_nxt_s;
      count_r     <= count_nxt_s;
      out_valid_r <= (count_nxt_s != '0);
      // Hold the last head when the FIFO runs empty.
      if (count_nxt_s != '0) begin
        out_data_r <= head_nxt_s;
      end
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign cal_done  = cal_done_r;
  assign offset_o  = offset_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_padc_ocal.sv
// ---------------------------------------------------------------------------
// tb_padc_ocal - directed scoreboard bench for padc_ocal.
// The driver pushes the hand-computed corrected value of every sample that
// should enter the FIFO; an independent monitor pops and compares whenever the
// DUT hands over a FIFO entry.
// ---------------------------------------------------------------------------
module tb_padc_ocal;

  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic signed [7:0] dig_in;
  logic              cal_start;
  logic signed [7:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              cal_done;
  logic signed [7:0] offset_o;
  logic              overflow;

  int                checks = 0;
  int                errors = 0;
  logic signed [7:0] sb [$];
  bit                exp_ovf = 1'b0;

  padc_ocal #(.W(8), .PIPE_LAT(7), .CAL_LOG2N(4), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .dig_in    (dig_in),
    .cal_start (cal_start),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cal_done  (cal_done),
    .offset_o  (offset_o),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: the handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0d, expected no output", out_data);
      end else begin
        check("out_data", int'(out_data), int'(sb.pop_front()));
      end
    end
  end

  // One clock: drive inputs, predict FIFO acceptance, return #1 after the edge.
  task automatic step(input logic signed [7:0] d, input bit cal, input bit run,
                      input logic signed [7:0] e);
    dig_in    = d;
    cal_start = cal;
    @(negedge clk);
    #1;
    if (run) begin
      if (sb.size() < DEPTH) sb.push_back(e);
      else exp_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    cal_start = 1'b0;
  endtask

  // Calibration: RUN step with cal_start, 7 settle, 16 samples (a,b,a,b..), done.
  task automatic calibrate(input logic signed [7:0] d0, input logic signed [7:0] e0,
                           input logic signed [7:0] a, input logic signed [7:0] b,
                           input logic signed [7:0] exp_off, input bit poke);
    logic signed [7:0] dd;
    exp_ovf = 1'b0;
    step(d0, 1'b1, 1'b1, e0);
    for (int k = 1; k <= 24; k++) begin
      if (k >= 8 && k <= 23) dd = ((k - 8) % 2 == 0) ? a : b;
      else dd = a;
      step(dd, poke && (k == 3 || k == 15), 1'b0, 8'sd0);
      check("cal_done", int'(cal_done), int'(k == 24));
      if (k >= 6) check("no_push_in_cal", int'(out_valid), 0);
      if (k == 24) begin
        check("offset_o", int'(offset_o), int'(exp_off));
        check("overflow_after_cal", int'(overflow), int'(exp_ovf));
      end
    end
  endtask

  initial begin
    rstn      = 1'b0;
    dig_in    = 8'sd5;
    cal_start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_cal_done", int'(cal_done), 0);
    check("rst_offset", int'(offset_o), 0);
    check("rst_overflow", int'(overflow), 0);
    rstn = 1'b1;

    // 1: warm-up, first valid PIPE_LAT+1 cycles after release.
    for (int k = 1; k <= 7; k++) begin
      step(8'sd5, 1'b0, 1'b0, 8'sd0);
      check("warm_out_valid", int'(out_valid), 0);
    end
    step(8'sd5, 1'b0, 1'b1, 8'sd5);
    check("first_out_valid", int'(out_valid), 1);
    check("first_out_data", int'(out_data), 5);
    repeat (3) step(8'sd5, 1'b0, 1'b1, 8'sd5);

    // 2: calibrate on constant 3, then 10 - 3 = 7.
    calibrate(8'sd3, 8'sd3, 8'sd3, 8'sd3, 8'sd3, 1'b0);
    step(8'sd10, 1'b0, 1'b1, 8'sd7);
    check("cal_done_pulse_end", int'(cal_done), 0);
    step(8'sd10, 1'b0, 1'b1, 8'sd7);

    // 3: rounding, with cal_start pokes during CAL that must be ignored.
    calibrate(8'sd10, 8'sd7, 8'sd1, 8'sd2, 8'sd2, 1'b1);
    step(8'sd2, 1'b0, 1'b1, 8'sd0);
    step(8'sd5, 1'b0, 1'b1, 8'sd3);
    calibrate(8'sd5, 8'sd3, -8'sd1, -8'sd2, -8'sd1, 1'b0);
    step(8'sd0, 1'b0, 1'b1, 8'sd1);
    step(-8'sd1, 1'b0, 1'b1, 8'sd0);

    // 4: saturation at both rails.
    calibrate(8'sd0, 8'sd1, -8'sd5, -8'sd5, -8'sd5, 1'b0);
    step(8'sd127, 1'b0, 1'b1, 8'sd127);
    step(8'sd0, 1'b0, 1'b1, 8'sd5);
    step(-8'sd128, 1'b0, 1'b1, -8'sd123);
    calibrate(8'sd0, 8'sd5, 8'sd5, 8'sd5, 8'sd5, 1'b0);
    step(-8'sd127, 1'b0, 1'b1, -8'sd128);
    step(8'sd127, 1'b0, 1'b1, 8'sd122);
    step(8'sd0, 1'b0, 1'b1, -8'sd5);

    // 5: backpressure with drops, then full FIFO with same-cycle pop.
    calibrate(8'sd0, -8'sd5, 8'sd0, 8'sd0, 8'sd0, 1'b0);
    out_ready = 1'b0;
    for (int d = 1; d <= 10; d++) step(8'(d), 1'b0, 1'b1, 8'(d));
    check("bp_overflow", int'(overflow), int'(exp_ovf));
    check("bp_overflow_set", int'(overflow), 1);
    check("bp_head", int'(out_data), 1);
    out_ready = 1'b1;
    for (int d = 11; d <= 16; d++) step(8'(d), 1'b0, 1'b1, 8'(d));
    calibrate(8'sd17, 8'sd17, 8'sd0, 8'sd0, 8'sd0, 1'b0);
    out_ready = 1'b0;
    for (int d = 21; d <= 24; d++) step(8'(d), 1'b0, 1'b1, 8'(d));
    check("full_out_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    for (int d = 25; d <= 30; d++) step(8'(d), 1'b0, 1'b1, 8'(d));
    check("pop_push_no_overflow", int'(overflow), 0);

    // 6: reset in the middle of CAL_ACC.
    calibrate(8'sd31, 8'sd31, 8'sd3, 8'sd3, 8'sd3, 1'b0);
    step(8'sd3, 1'b1, 1'b1, 8'sd0);
    for (int k = 1; k <= 12; k++) begin
      step(8'sd3, k == 4, 1'b0, 8'sd0);
      check("abort_cal_done", int'(cal_done), 0);
    end
    rstn = 1'b0;
    #1;
    sb.delete();
    exp_ovf = 1'b0;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_data", int'(out_data), 0);
    check("mid_rst_cal_done", int'(cal_done), 0);
    check("mid_rst_offset", int'(offset_o), 0);
    check("mid_rst_overflow", int'(overflow), 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(8'sd9, (k == 2) || (k == 5), 1'b0, 8'sd0);
      check("rewarm_out_valid", int'(out_valid), 0);
      check("rewarm_cal_done", int'(cal_done), 0);
    end
    step(8'sd9, 1'b0, 1'b1, 8'sd9);
    check("rerun_out_valid", int'(out_valid), 1);
    check("rerun_out_data", int'(out_data), 9);
    for (int k = 0; k < 3; k++) begin
      step(8'sd9, 1'b0, 1'b1, 8'sd9);
      check("rerun_cal_done", int'(cal_done), 0);
    end
    check("rerun_offset", int'(offset_o), 0);

    @(negedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
